mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, bus cycles allowed per transaction before abort.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  fetch request, held until if_ready.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_rdata  output  32  fetched word, valid with if_ready.
REQ-007 if_ready  output  1  one-cycle completion pulse for fetch.
REQ-008 M_memread  input  1  M-stage load request, held until m_ready.
REQ-009 M_memwrite  input  1  M-stage store request, held until m_ready.
REQ-010 M_memaddr  input  32  data address.
REQ-011 M_wdata  input  32  store data.
REQ-012 M_wstrb  input  4  store byte enables.
REQ-013 m_rdata  output  32  load data, valid with m_ready.
REQ-014 m_ready  output  1  one-cycle completion pulse for data access.
REQ-015 F_stall  output  1  fetch stall, combinational: if_req & ~if_ready.
REQ-016 M_stall  output  1  M stall, combinational: (M_memread|M_memwrite) & ~m_ready.
REQ-017 bus_req, bus_we  output  1 each  registered bus request / write select.
REQ-018 bus_addr, bus_wdata  output  32 each; bus_wstrb  output  4; all registered.
REQ-019 bus_ack  input  1; bus_rdata  input  32  single-port memory response.
REQ-020 bus_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-021 FSM states IDLE, DATA, INST; all bus outputs registered, changing only on state entry/exit.
REQ-022 IDLE: a pending data request enters DATA next edge; else a pending fetch enters INST; else stay.
REQ-023 Both pending in IDLE: data wins unless last_grant==DATA and previous transaction ended the prior cycle, then INST wins (no fetch starvation).
REQ-024 DATA/INST: bus_req=1, address/data/strobes frozen; bus_we=1 only for DATA with M_memwrite; bus_wstrb=0 for reads.
REQ-025 bus_ack in DATA/INST: capture bus_rdata into m_rdata/if_rdata, pulse the matching ready next cycle, drop bus_req, return to IDLE.
REQ-026 Minimum latency: request at edge N, bus_req from N+1, ack at N+1 gives ready at N+2; one transaction per two cycles minimum.
REQ-027 M_memread and M_memwrite both high: treated as write.
REQ-028 8-bit wait counter clears on entry to DATA/INST, increments each cycle without ack; at TIMEOUT: drop bus_req, pulse bus_err and the matching ready (rdata=0), go IDLE.
REQ-029 Ack and timeout in same cycle: ack wins, no bus_err.
REQ-030 bus_ack in IDLE ignored; if_rdata/m_rdata hold last value between transactions.

Reset
REQ-031 rst asserted: state IDLE, last_grant=INST, counter 0, bus_req/bus_we/bus_err/if_ready/m_ready 0, bus_addr/bus_wdata/bus_wstrb/if_rdata/m_rdata 0, immediately without clock.
REQ-032 Reset mid-transaction aborts without a ready pulse; first grant is re-arbitrated on the first edge after deassert.

Structure
REQ-033 State encoding (IDLE=2'd0, DATA=2'd1, INST=2'd2) and TIMEOUT default live in the shared mips_pkg package.
REQ-034 Single flat module; no sub-module is natural.

Verification
REQ-035 Fetch 0x00400000, ack after 3 cycles with 0x8C080004 -> if_ready one pulse, if_rdata=0x8C080004, F_stall high until that pulse.
REQ-036 Store 0xDEADBEEF to 0x10010000, wstrb 4'b0011, immediate ack -> bus_we=1, bus_wstrb=0011, m_ready at N+2, M_stall low after.
REQ-037 Fetch and load both pending from reset, continuous -> DATA granted first, INST next, alternating thereafter.
REQ-038 Load with no ack, TIMEOUT=4 -> bus_req high 4 cycles, then bus_err and m_ready pulse, m_rdata=0.
REQ-039 rst asserted mid-DATA -> bus_req falls asynchronously, no m_ready; request still held reissued after release.
REQ-040 Ack on the TIMEOUT cycle -> normal completion, bus_err stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory subsystem: arbiter state
// encoding and the default bus timeout.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch port and the M-stage data port onto one
// single-port memory bus. Data accesses win ties, except directly after a
// data transaction when a fetch is also waiting, so fetches never starve.
// A transaction that sees no bus_ack for TIMEOUT cycles is aborted with a
// bus_err pulse and completes with zero read data.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        M_memread,
  input  logic        M_memwrite,
  input  logic [31:0] M_memaddr,
  input  logic [31:0] M_wdata,
  input  logic [3:0]  M_wstrb,
  output logic [31:0] m_rdata,
  output logic        m_ready,
  output logic        F_stall,
  output logic        M_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  // Wait count of the last cycle a transaction may spend on the bus.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  arb_state_t state;
  arb_state_t last_grant;
  logic [7:0] wait_cnt;
  logic       ended_prev;
  logic       data_pend;
  logic       inst_pend;
  logic       pick_data;
  logic       timeout_hit;

  // A request whose ready pulse is showing this cycle is already served,
  // so the stall terms double as "still pending" for arbitration.
  assign F_stall     = if_req & ~if_ready;
  assign M_stall     = (M_memread | M_memwrite) & ~m_ready;
  assign data_pend   = M_stall;
  assign inst_pend   = F_stall;
  assign timeout_hit = (wait_cnt == LAST_WAIT);

  // Grant choice: data first, but yield to a waiting fetch right after a data transaction.
  always_comb begin
    pick_data = data_pend;
    if (data_pend && inst_pend) begin
      pick_data = !((last_grant == DATA) && ended_prev);
    end
  end

  // Arbiter FSM with all bus and completion outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= INST;
      wait_cnt   <= 8'd0;
      ended_prev <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_err    <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      bus_wstrb  <= 4'd0;
      if_ready   <= 1'b0;
      m_ready    <= 1'b0;
      if_rdata   <= 32'd0;
      m_rdata    <= 32'd0;
    end else begin
      if_ready   <= 1'b0;
      m_ready    <= 1'b0;
      bus_err    <= 1'b0;
      ended_prev <= 1'b0;
      case (state)
        IDLE: begin
          if (data_pend || inst_pend) begin
            wait_cnt <= 8'd0;
            bus_req  <= 1'b1;
            if (pick_data) begin
              state      <= DATA;
              last_grant <= DATA;
              bus_addr   <= M_memaddr;
              bus_we     <= M_memwrite;
              bus_wdata  <= M_wdata;
              bus_wstrb  <= M_memwrite ? M_wstrb : 4'd0;
            end else begin
              state      <= INST;
              last_grant <= INST;
              bus_addr   <= if_addr;
              bus_we     <= 1'b0;
              bus_wdata  <= 32'd0;
              bus_wstrb  <= 4'd0;
            end
          end
        end
        DATA, INST: begin
          if (bus_ack || timeout_hit) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            ended_prev <= 1'b1;
            bus_err    <= !bus_ack;
            if (state == DATA) begin
              m_ready <= 1'b1;
              m_rdata <= bus_ack ? bus_rdata : 32'd0;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= bus_ack ? bus_rdata : 32'd0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transaction table,
// hand-written corner sequences, then randomized traffic against a
// transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        M_memread;
  logic        M_memwrite;
  logic [31:0] M_memaddr;
  logic [31:0] M_wdata;
  logic [3:0]  M_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        F_stall;
  logic        M_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .M_memread(M_memread), .M_memwrite(M_memwrite), .M_memaddr(M_memaddr),
    .M_wdata(M_wdata), .M_wstrb(M_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
    .F_stall(F_stall), .M_stall(M_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    bit          is_fetch;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ack_delay;
    logic [31:0] rdata;
    bit          exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  // Reference model state: who owns the bus and for how long.
  int          mdl_owner;
  int          mdl_age;
  bit          mdl_last_data;
  bit          mdl_just_done;
  logic        exp_req, exp_we, exp_err, exp_if_rdy, exp_m_rdy;
  logic [31:0] exp_addr, exp_if_rdata, exp_m_rdata;
  logic [3:0]  exp_wstrb;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    if_req = 0; if_addr = 0;
    M_memread = 0; M_memwrite = 0; M_memaddr = 0; M_wdata = 0; M_wstrb = 0;
    bus_ack = 0; bus_rdata = 0;
  endtask

  task automatic applyReset();
    rst = 1;
    clearInputs();
    @(posedge clk); #1;
    rst = 0;
  endtask

  // One isolated transaction from IDLE, responder acks after ack_delay bus cycles.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   k;
    bit   done;
    logic rdy;
    k = 0;
    done = 0;
    bus_rdata = v.rdata;
    bus_ack = 0;
    if (v.is_fetch) begin
      if_req = 1; if_addr = v.addr;
    end else begin
      M_memread = v.rd; M_memwrite = v.wr; M_memaddr = v.addr;
      M_wdata = v.wdata; M_wstrb = v.wstrb;
    end
    for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
      @(posedge clk); #1;
      rdy = v.is_fetch ? if_ready : m_ready;
      if (rdy) begin
        done = 1;
        bus_ack = 0;
        checkOutput({tag, " latency"}, cyc, v.exp_lat);
        checkOutput({tag, " rdata"}, v.is_fetch ? if_rdata : m_rdata, v.exp_rdata);
        checkOutput({tag, " bus_err"}, bus_err, v.exp_err);
        checkOutput({tag, " stall at ready"}, v.is_fetch ? F_stall : M_stall, 0);
        checkOutput({tag, " bus_req at ready"}, bus_req, 0);
      end else begin
        checkOutput({tag, " stall while waiting"}, v.is_fetch ? F_stall : M_stall, 1);
        if (bus_req) begin
          if (k == 0) begin
            checkOutput({tag, " bus_addr"}, bus_addr, v.addr);
            checkOutput({tag, " bus_we"}, bus_we, v.exp_we);
            checkOutput({tag, " bus_wstrb"}, bus_wstrb, v.exp_wstrb);
            if (v.exp_we) checkOutput({tag, " bus_wdata"}, bus_wdata, v.wdata);
          end
          bus_ack = (k == v.ack_delay);
          k++;
        end else begin
          bus_ack = 0;
        end
      end
    end
    if (!done) begin
      n_checks++; n_fails++;
      $display("[TB] FAIL %s no ready within 20 cycles: got none, expected a pulse", tag);
    end
    clearInputs();
    @(posedge clk); #1;
    checkOutput({tag, " ready is one pulse"}, v.is_fetch ? if_ready : m_ready, 0);
  endtask

  task automatic modelReset();
    mdl_owner = 0; mdl_age = 0; mdl_last_data = 0; mdl_just_done = 0;
    exp_req = 0; exp_we = 0; exp_err = 0; exp_if_rdy = 0; exp_m_rdy = 0;
    exp_addr = 0; exp_if_rdata = 0; exp_m_rdata = 0; exp_wstrb = 0;
  endtask

  // Advance the model over one clock edge using the inputs presented now.
  task automatic modelEdge();
    bit          want_d, want_f, take_d, prev_done;
    logic [31:0] rd;
    want_d = (M_memread || M_memwrite) && !exp_m_rdy;
    want_f = if_req && !exp_if_rdy;
    prev_done = mdl_just_done;
    mdl_just_done = 0;
    exp_if_rdy = 0; exp_m_rdy = 0; exp_err = 0;
    if (mdl_owner == 0) begin
      if (want_d || want_f) begin
        take_d = want_d && !(want_f && mdl_last_data && prev_done);
        mdl_owner = take_d ? 1 : 2;
        mdl_age = 0;
        mdl_last_data = take_d;
        exp_req = 1;
        exp_addr = take_d ? M_memaddr : if_addr;
        exp_we = take_d && M_memwrite;
        exp_wstrb = exp_we ? M_wstrb : 4'd0;
      end
    end else if (bus_ack || mdl_age == TO - 1) begin
      rd = bus_ack ? bus_rdata : 32'd0;
      exp_err = !bus_ack;
      exp_req = 0;
      exp_we = 0;
      if (mdl_owner == 1) begin exp_m_rdy = 1; exp_m_rdata = rd; end
      else begin exp_if_rdy = 1; exp_if_rdata = rd; end
      mdl_owner = 0;
      mdl_just_done = 1;
    end else begin
      mdl_age++;
    end
  endtask

  // Hard stop in case something wedges the stimulus.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int          n_grants;
    logic        prev_req;
    bit          seen;
    int          r;

    vecs[0] = '{1, 0, 0, 32'h00400000, 32'h0, 4'h0, 3, 32'h8C080004, 0, 4'h0, 32'h8C080004, 0, 5};
    vecs[1] = '{0, 0, 1, 32'h10010000, 32'hDEADBEEF, 4'b0011, 0, 32'h0, 1, 4'b0011, 32'h0, 0, 2};
    vecs[2] = '{0, 1, 0, 32'h10010004, 32'h0, 4'hF, 1, 32'h12345678, 0, 4'h0, 32'h12345678, 0, 3};
    vecs[3] = '{0, 1, 0, 32'h10010008, 32'h0, 4'h0, 99, 32'hFFFFFFFF, 0, 4'h0, 32'h0, 1, 5};
    vecs[4] = '{0, 1, 0, 32'h1001000C, 32'h0, 4'h0, 3, 32'hA5A5A5A5, 0, 4'h0, 32'hA5A5A5A5, 0, 5};
    vecs[5] = '{0, 1, 1, 32'h00002000, 32'h11223344, 4'b1111, 0, 32'h55AA55AA, 1, 4'b1111, 32'h55AA55AA, 0, 2};
    vecs[6] = '{1, 0, 0, 32'h00400004, 32'h0, 4'h0, 99, 32'h77777777, 0, 4'h0, 32'h0, 1, 5};

    rst = 0;
    clearInputs();
    #1 rst = 1;
    #1;
    checkOutput("reset bus_req", bus_req, 0);
    checkOutput("reset bus_we", bus_we, 0);
    checkOutput("reset bus_err", bus_err, 0);
    checkOutput("reset if_ready", if_ready, 0);
    checkOutput("reset m_ready", m_ready, 0);
    checkOutput("reset bus_addr", bus_addr, 0);
    checkOutput("reset bus_wdata", bus_wdata, 0);
    checkOutput("reset bus_wstrb", bus_wstrb, 0);
    checkOutput("reset if_rdata", if_rdata, 0);
    checkOutput("reset m_rdata", m_rdata, 0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Acks while idle must be ignored and read data must hold.
    bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("idle ack m_ready", m_ready, 0);
      checkOutput("idle ack if_ready", if_ready, 0);
      checkOutput("idle ack bus_req", bus_req, 0);
    end
    checkOutput("idle ack m_rdata held", m_rdata, 32'h55AA55AA);
    checkOutput("idle ack if_rdata held", if_rdata, 32'h0);
    bus_ack = 0;

    // Continuous load and fetch from reset: grants alternate, data first.
    rst = 1;
    clearInputs();
    M_memread = 1; M_memaddr = 32'h10000000;
    if_req = 1; if_addr = 32'h00400000;
    bus_rdata = 32'h01020304;
    @(posedge clk); #1;
    rst = 0;
    n_grants = 0;
    prev_req = 0;
    for (int c = 0; c < 40 && n_grants < 6; c++) begin
      @(posedge clk); #1;
      if (bus_req && !prev_req) begin
        checkOutput($sformatf("alternate grant %0d", n_grants), bus_addr,
                    (n_grants % 2 == 0) ? 32'h10000000 : 32'h00400000);
        n_grants++;
      end
      prev_req = bus_req;
      bus_ack = bus_req;
    end
    if (n_grants < 6) begin
      n_checks++; n_fails++;
      $display("[TB] FAIL alternate grants: got %0d, expected 6", n_grants);
    end

    // Reset in the middle of a data transaction.
    applyReset();
    M_memread = 1; M_memaddr = 32'h10000040;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk); #1;
      seen = bus_req;
    end
    checkOutput("mid reset bus_req before", bus_req, 1);
    rst = 1;
    #1;
    checkOutput("mid reset async bus_req", bus_req, 0);
    checkOutput("mid reset m_ready", m_ready, 0);
    @(posedge clk); #1;
    checkOutput("mid reset m_ready held in reset", m_ready, 0);
    rst = 0;
    @(posedge clk); #1;
    checkOutput("reissue bus_req", bus_req, 1);
    checkOutput("reissue bus_addr", bus_addr, 32'h10000040);
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    checkOutput("reissue m_ready", m_ready, 1);
    checkOutput("reissue m_rdata", m_rdata, 32'hCAFEF00D);
    clearInputs();

    // Randomized traffic against the reference model.
    applyReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      checkOutput("rnd bus_req", bus_req, exp_req);
      checkOutput("rnd bus_err", bus_err, exp_err);
      checkOutput("rnd if_ready", if_ready, exp_if_rdy);
      checkOutput("rnd m_ready", m_ready, exp_m_rdy);
      checkOutput("rnd if_rdata", if_rdata, exp_if_rdata);
      checkOutput("rnd m_rdata", m_rdata, exp_m_rdata);
      if (exp_req) begin
        checkOutput("rnd bus_addr", bus_addr, exp_addr);
        checkOutput("rnd bus_we", bus_we, exp_we);
        checkOutput("rnd bus_wstrb", bus_wstrb, exp_wstrb);
      end
      if (M_memread || M_memwrite) begin
        if (exp_m_rdy) begin M_memread = 0; M_memwrite = 0; end
      end else if ($urandom_range(2) == 0) begin
        r = $urandom_range(2);
        M_memread = (r == 0 || r == 2);
        M_memwrite = (r == 1 || r == 2);
        M_memaddr = $urandom & 32'hFFFFFFFC;
        M_wdata = $urandom;
        M_wstrb = 4'($urandom_range(15));
      end
      if (if_req) begin
        if (exp_if_rdy) if_req = 0;
      end else if ($urandom_range(2) == 0) begin
        if_req = 1;
        if_addr = $urandom & 32'hFFFFFFFC;
      end
      bus_ack = exp_req ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      bus_rdata = $urandom;
      modelEdge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
